// File: rtl/dds_phase_to_amp.sv
`default_nettype none
// ============================================================================
//  Module   : dds_phase_to_amp
//  Brief    : Phase-to-amplitude converter for the DDS chain. Maps the top
//             eight phase bits to an 8-bit unsigned sample (sine from a
//             quarter-wave ROM, square, triangle, sawtooth) and applies an
//             optional amplitude scale. Three register stages, latency 3.
//  Revision : 1.0  initial release
// ============================================================================
module dds_phase_to_amp #(
   parameter int PHASE_W  = 8,     // incoming phase width, must be >= 8
   parameter bit SCALE_EN = 1'b1   // 1: apply amp_scale in the last stage
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PHASE_W-1:0] phase_in,
   input  logic               phase_valid,
   input  logic [1:0]         wave_sel,
   input  logic [7:0]         amp_scale,
   output logic [7:0]         amp_out,
   output logic               amp_valid
);

   // Waveform selector encoding.
   localparam logic [1:0] C_SEL_SINE   = 2'd0;
   localparam logic [1:0] C_SEL_SQUARE = 2'd1;
   localparam logic [1:0] C_SEL_TRI    = 2'd2;
   localparam logic [1:0] C_SEL_SAW    = 2'd3;

   // ------------------------------------------------------------------------
   // Quarter-wave sine ROM: Q[k] = round(127.5*sin(2*pi*(k+0.5)/256)).
   // The half-step offset makes the table symmetric about the quadrant
   // boundaries, so folding the address with a plain bit inversion is exact.
   // ------------------------------------------------------------------------
   function automatic logic [6:0] sine_rom(input logic [5:0] addr);
      logic [6:0] q;
      case (addr)
         6'd0:    q = 7'd2;
         6'd1:    q = 7'd5;
         6'd2:    q = 7'd8;
         6'd3:    q = 7'd11;
         6'd4:    q = 7'd14;
         6'd5:    q = 7'd17;
         6'd6:    q = 7'd20;
         6'd7:    q = 7'd23;
         6'd8:    q = 7'd26;
         6'd9:    q = 7'd29;
         6'd10:   q = 7'd32;
         6'd11:   q = 7'd36;
         6'd12:   q = 7'd39;
         6'd13:   q = 7'd41;
         6'd14:   q = 7'd44;
         6'd15:   q = 7'd47;
         6'd16:   q = 7'd50;
         6'd17:   q = 7'd53;
         6'd18:   q = 7'd56;
         6'd19:   q = 7'd59;
         6'd20:   q = 7'd61;
         6'd21:   q = 7'd64;
         6'd22:   q = 7'd67;
         6'd23:   q = 7'd70;
         6'd24:   q = 7'd72;
         6'd25:   q = 7'd75;
         6'd26:   q = 7'd77;
         6'd27:   q = 7'd80;
         6'd28:   q = 7'd82;
         6'd29:   q = 7'd84;
         6'd30:   q = 7'd87;
         6'd31:   q = 7'd89;
         6'd32:   q = 7'd91;
         6'd33:   q = 7'd93;
         6'd34:   q = 7'd96;
         6'd35:   q = 7'd98;
         6'd36:   q = 7'd100;
         6'd37:   q = 7'd101;
         6'd38:   q = 7'd103;
         6'd39:   q = 7'd105;
         6'd40:   q = 7'd107;
         6'd41:   q = 7'd109;
         6'd42:   q = 7'd110;
         6'd43:   q = 7'd112;
         6'd44:   q = 7'd113;
         6'd45:   q = 7'd115;
         6'd46:   q = 7'd116;
         6'd47:   q = 7'd117;
         6'd48:   q = 7'd118;
         6'd49:   q = 7'd120;
         6'd50:   q = 7'd121;
         6'd51:   q = 7'd122;
         6'd52:   q = 7'd122;
         6'd53:   q = 7'd123;
         6'd54:   q = 7'd124;
         6'd55:   q = 7'd125;
         6'd56:   q = 7'd125;
         6'd57:   q = 7'd126;
         6'd58:   q = 7'd126;
         6'd59:   q = 7'd127;
         6'd60:   q = 7'd127;
         6'd61:   q = 7'd127;
         6'd62:   q = 7'd127;
         6'd63:   q = 7'd127;
         default: q = 7'd127;
      endcase
      return q;
   endfunction

   // ------------------------------------------------------------------------
   // Stage 1: truncated phase, folded ROM address, and the per-sample
   // controls. Capturing sel/scale here ties them to their own sample, so a
   // change never disturbs samples already in flight.
   // ------------------------------------------------------------------------
   logic [7:0] s1_p_d,     s1_p_q;
   logic [5:0] s1_addr_d,  s1_addr_q;
   logic [1:0] s1_sel_d,   s1_sel_q;
   logic [7:0] s1_scale_d, s1_scale_q;
   logic       s1_valid_d, s1_valid_q;

   // Stage 2: selected waveform sample.
   logic [7:0] s2_wave_d,  s2_wave_q;
   logic [7:0] s2_scale_d, s2_scale_q;
   logic       s2_valid_d, s2_valid_q;

   // Stage 3: scaled output; holds its value across bubbles.
   logic [7:0] amp_d,       amp_q;
   logic       amp_valid_d, amp_valid_q;

   // Waveform candidates and scaler result.
   logic [6:0] w_sine_q;
   logic [7:0] w_sine;
   logic [7:0] w_square;
   logic [7:0] w_tri_t;
   logic [7:0] w_tri;
   logic [7:0] w_saw;
   logic [7:0] w_scaled;

   // Stage 1 next-state: only the top eight phase bits carry amplitude info.
   always_comb begin
      s1_p_d     = phase_in[PHASE_W-1 -: 8];
      s1_addr_d  = s1_p_d[6] ? ~s1_p_d[5:0] : s1_p_d[5:0];
      s1_sel_d   = wave_sel;
      s1_scale_d = amp_scale;
      s1_valid_d = phase_valid;
   end

   // Stage 2 next-state: build all four waveforms and select one.
   always_comb begin
      w_sine_q = sine_rom(s1_addr_q);
      // Upper half-cycle mirrors below mid-scale: 127-Q vs 128+Q keeps the
      // wave symmetric about 127.5 without a sign bit.
      w_sine   = s1_p_q[7] ? (8'd127 - {1'b0, w_sine_q})
                           : (8'd128 + {1'b0, w_sine_q});
      w_square = s1_p_q[7] ? 8'd0 : 8'd255;
      w_tri_t  = {s1_p_q[6:0], 1'b0};
      w_tri    = s1_p_q[7] ? ~w_tri_t : w_tri_t;
      w_saw    = s1_p_q;

      case (s1_sel_q)
         C_SEL_SINE:   s2_wave_d = w_sine;
         C_SEL_SQUARE: s2_wave_d = w_square;
         C_SEL_TRI:    s2_wave_d = w_tri;
         C_SEL_SAW:    s2_wave_d = w_saw;
         default:      s2_wave_d = w_sine;
      endcase
      s2_scale_d = s1_scale_q;
      s2_valid_d = s1_valid_q;
   end

   // Amplitude scaler: (wave * (scale+1)) >> 8. scale=255 is unity gain and
   // the 17-bit product can never exceed 255 after the shift.
   generate
      if (SCALE_EN) begin : g_scale
         logic [8:0]  w_scale_p1;
         logic [16:0] w_product;
         logic        w_unused_prod_bits;
         assign w_scale_p1         = {1'b0, s2_scale_q} + 9'd1;
         assign w_product          = {8'd0, w_scale_p1} * {9'd0, s2_wave_q};
         assign w_scaled           = w_product[15:8];
         // Bit 16 is always zero and the low byte is the truncated fraction.
         assign w_unused_prod_bits = ^{w_product[16], w_product[7:0]};
      end else begin : g_no_scale
         logic w_unused_scale;
         assign w_scaled       = s2_wave_q;
         assign w_unused_scale = ^s2_scale_q;
      end
   endgenerate

   // Phase bits below the top byte carry no amplitude information.
   generate
      if (PHASE_W > 8) begin : g_phase_lsbs
         logic w_unused_phase_lsbs;
         assign w_unused_phase_lsbs = ^phase_in[PHASE_W-9:0];
      end
   endgenerate

   // Stage 3 next-state: update the output only for valid samples so the
   // last value is held through bubbles.
   always_comb begin
      amp_d       = s2_valid_q ? w_scaled : amp_q;
      amp_valid_d = s2_valid_q;
   end

   // Pipeline registers; reset flushes every stage so nothing in flight
   // survives.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_p_q      <= 8'd0;
         s1_addr_q   <= 6'd0;
         s1_sel_q    <= 2'd0;
         s1_scale_q  <= 8'd0;
         s1_valid_q  <= 1'b0;
         s2_wave_q   <= 8'd0;
         s2_scale_q  <= 8'd0;
         s2_valid_q  <= 1'b0;
         amp_q       <= 8'd0;
         amp_valid_q <= 1'b0;
      end else begin
         s1_p_q      <= s1_p_d;
         s1_addr_q   <= s1_addr_d;
         s1_sel_q    <= s1_sel_d;
         s1_scale_q  <= s1_scale_d;
         s1_valid_q  <= s1_valid_d;
         s2_wave_q   <= s2_wave_d;
         s2_scale_q  <= s2_scale_d;
         s2_valid_q  <= s2_valid_d;
         amp_q       <= amp_d;
         amp_valid_q <= amp_valid_d;
      end
   end

   assign amp_out   = amp_q;
   assign amp_valid = amp_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_to_amp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_phase_to_amp
//  Brief    : Directed/random bench for dds_phase_to_amp. Expected samples are
//             computed from the waveform definitions (sine via $sin) and
//             queued with their due cycle; outputs are compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dds_phase_to_amp;

   localparam int PHASE_W = 8;
   localparam real C_PI   = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               reset;
   logic [PHASE_W-1:0] phase_in;
   logic               phase_valid;
   logic [1:0]         wave_sel;
   logic [7:0]         amp_scale;
   logic [7:0]         amp_out;
   logic               amp_valid;

   typedef struct {
      int         due;
      logic [7:0] val;
   } exp_t;

   exp_t       sb[$];
   int         cyc      = 0;
   int         n_vec    = 0;
   int         n_err    = 0;
   logic [7:0] exp_last = 8'd0;

   dds_phase_to_amp #(
      .PHASE_W  (PHASE_W),
      .SCALE_EN (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .phase_in    (phase_in),
      .phase_valid (phase_valid),
      .wave_sel    (wave_sel),
      .amp_scale   (amp_scale),
      .amp_out     (amp_out),
      .amp_valid   (amp_valid)
   );

   always #5 clk = ~clk;

   // Reference waveform from its mathematical definition.
   function automatic int model(input int p, input int sel, input int sc);
      int  w;
      real v;
      case (sel)
         0: begin
            v = 127.5 * $sin(2.0 * C_PI * (real'(p) + 0.5) / 256.0);
            if (v >= 0.0) w = 128 + $rtoi(v + 0.5);
            else          w = 127 - $rtoi(-v + 0.5);
         end
         1:       w = (p < 128) ? 255 : 0;
         2:       w = (p < 128) ? 2 * p : 511 - 2 * p;
         default: w = p;
      endcase
      return (w * (sc + 1)) / 256;
   endfunction

   // Compare current outputs against the scoreboard head.
   task automatic check_outputs();
      logic       ev;
      logic [7:0] eo;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         ev       = 1'b1;
         eo       = sb[0].val;
         exp_last = eo;
         void'(sb.pop_front());
      end else begin
         ev = 1'b0;
         eo = exp_last;
      end
      n_vec++;
      assert (amp_valid === ev) else begin
         n_err++;
         $error("FAIL amp_valid cyc=%0d observed=%b expected=%b", cyc, amp_valid, ev);
      end
      n_vec++;
      assert (amp_out === eo) else begin
         n_err++;
         $error("FAIL amp_out cyc=%0d observed=%0d expected=%0d", cyc, amp_out, eo);
      end
   endtask

   // Drive one cycle of stimulus, predict its outcome, then check.
   task automatic step(input bit v, input int p, input int sel, input int sc, input bit rst);
      int pv;
      int sv;
      int cv;
      exp_t e;
      pv          = p;
      sv          = sel;
      cv          = sc;
      reset       = rst;
      phase_valid = v;
      phase_in    = pv[7:0];
      wave_sel    = sv[1:0];
      amp_scale   = cv[7:0];
      if (rst) begin
         sb.delete();
         exp_last = 8'd0;
      end else if (v) begin
         e.due = cyc + 3;
         e.val = 8'(model(p, sel, sc));
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 255, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      phase_valid = 1'b0;
      phase_in    = '0;
      wave_sel    = 2'd0;
      amp_scale   = 8'd255;

      // Reset held two cycles while phase_valid is high.
      step(1'b1, 5, 0, 255, 1'b1);
      step(1'b1, 9, 0, 255, 1'b1);

      // Sine quadrant points back to back.
      step(1'b1,   0, 0, 255, 1'b0);
      step(1'b1,  63, 0, 255, 1'b0);
      step(1'b1,  64, 0, 255, 1'b0);
      step(1'b1, 128, 0, 255, 1'b0);
      step(1'b1, 192, 0, 255, 1'b0);
      step(1'b1, 255, 0, 255, 1'b0);
      idle(4);

      // Square, triangle, sawtooth at unity scale.
      step(1'b1,  10, 1, 255, 1'b0);
      step(1'b1, 200, 1, 255, 1'b0);
      step(1'b1,   0, 2, 255, 1'b0);
      step(1'b1, 127, 2, 255, 1'b0);
      step(1'b1, 128, 2, 255, 1'b0);
      step(1'b1, 255, 2, 255, 1'b0);
      step(1'b1,  77, 3, 255, 1'b0);
      idle(4);

      // Amplitude scaling.
      step(1'b1, 64, 0, 127, 1'b0);
      step(1'b1, 64, 0,   0, 1'b0);
      step(1'b1,  0, 1,  63, 1'b0);
      idle(4);

      // Bubble with a wave change on the third sample; output holds in gap.
      step(1'b1,  0, 0, 255, 1'b0);
      step(1'b0, 33, 1,  17, 1'b0);
      step(1'b1,  0, 1, 255, 1'b0);
      idle(4);

      // Reset mid-stream: in-flight samples must vanish.
      for (int i = 0; i < 6; i++) step(1'b1, 20 * i, 2, 255, 1'b0);
      step(1'b1, 99, 2, 255, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 30 + 7 * i, 3, 200, 1'b0);
      idle(4);

      // Full sine sweep across the wrap, then triangle sweep.
      for (int p = 0; p < 256; p++) step(1'b1, p, 0, 255, 1'b0);
      step(1'b1, 0, 0, 255, 1'b0);
      for (int p = 0; p < 256; p += 3) step(1'b1, p, 2, 255, 1'b0);
      idle(4);

      // Random mix of waves, scales and bubbles.
      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), 1'b0);
      idle(5);

      // Every queued sample must have emerged.
      n_vec++;
      assert (sb.size() == 0) else begin
         n_err++;
         $error("FAIL drain observed=%0d pending expected=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
